// File: rtl/mem_stage_lsu_if.sv
// Data-memory request/grant/response bus between the MEM-stage LSU and the data memory.
interface mem_stage_lsu_if;
    logic        Dmem_Req;
    logic        Dmem_We;
    logic [31:0] Dmem_Addr;
    logic [31:0] Dmem_Wdata;
    logic [3:0]  Dmem_Be;
    logic        Dmem_Gnt;
    logic        Dmem_Rvalid;
    logic [31:0] Dmem_Rdata;

    modport master (
        output Dmem_Req, Dmem_We, Dmem_Addr, Dmem_Wdata, Dmem_Be,
        input  Dmem_Gnt, Dmem_Rvalid, Dmem_Rdata
    );
    modport slave (
        input  Dmem_Req, Dmem_We, Dmem_Addr, Dmem_Wdata, Dmem_Be,
        output Dmem_Gnt, Dmem_Rvalid, Dmem_Rdata
    );
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: launches one data-memory access per instruction, stalls the
// pipeline while it is in flight, and aligns/extends load data for the MEM/WB register.
module mem_stage_lsu #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Valid_MEM,
    input  logic                 Load_MEM,
    input  logic                 Store_MEM,
    input  logic [2:0]           Funct3_MEM,
    input  logic [31:0]          Alu_Out_MEM,
    input  logic [31:0]          Store_Data_MEM,
    mem_stage_lsu_if.master      dmem,
    output logic [31:0]          Loaded_Data_MEM,
    output logic                 Stall_MEM,
    output logic                 Misaligned_MEM,
    output logic                 Timeout_MEM
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [1:0]    off_q;
    logic [2:0]    f3_q;
    logic          ld_q;

    logic       is_op, sz_b, sz_h, misal, start;
    logic [3:0] be_c;
    logic [31:0] wd_c;

    // Size comes from funct3[1:0]; the unsigned bit (funct3[2]) only matters for loads.
    always_comb begin
        is_op = Valid_MEM & (Load_MEM | Store_MEM);
        sz_b  = (Funct3_MEM[1:0] == 2'b00);
        sz_h  = (Funct3_MEM[1:0] == 2'b01);
        misal = sz_h ? Alu_Out_MEM[0] : (!sz_b && (Alu_Out_MEM[1:0] != 2'b00));
        start = is_op & ~misal;
        be_c  = 4'b1111;
        wd_c  = Store_Data_MEM;
        if (!Load_MEM) begin
            if (sz_b) begin
                be_c = 4'b0001 << Alu_Out_MEM[1:0];
                wd_c = {4{Store_Data_MEM[7:0]}};
            end else if (sz_h) begin
                be_c = Alu_Out_MEM[1] ? 4'b1100 : 4'b0011;
                wd_c = {2{Store_Data_MEM[15:0]}};
            end
        end
    end

    assign Stall_MEM      = ~Reset & (((state == IDLE) & start) | (state == REQ) | (state == WAIT_RSP));
    assign Misaligned_MEM = ~Reset & (state == IDLE) & is_op & misal;

    function automatic logic [31:0] fmt(input logic [31:0] raw, input logic [1:0] off,
                                        input logic [2:0] f3);
        logic [31:0] s;
        s = raw >> {off, 3'b000};
        case (f3)
            3'b000:  fmt = {{24{s[7]}}, s[7:0]};
            3'b100:  fmt = {24'd0, s[7:0]};
            3'b001:  fmt = {{16{s[15]}}, s[15:0]};
            3'b101:  fmt = {16'd0, s[15:0]};
            default: fmt = s;
        endcase
    endfunction

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state           <= IDLE;
            cnt             <= '0;
            off_q           <= '0;
            f3_q            <= '0;
            ld_q            <= 1'b0;
            dmem.Dmem_Req   <= 1'b0;
            dmem.Dmem_We    <= 1'b0;
            dmem.Dmem_Addr  <= '0;
            dmem.Dmem_Wdata <= '0;
            dmem.Dmem_Be    <= '0;
            Loaded_Data_MEM <= '0;
            Timeout_MEM     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt         <= '0;
                    Timeout_MEM <= 1'b0;
                    if (start) begin
                        state           <= REQ;
                        dmem.Dmem_Req   <= 1'b1;
                        dmem.Dmem_We    <= ~Load_MEM;
                        dmem.Dmem_Addr  <= {Alu_Out_MEM[31:2], 2'b00};
                        dmem.Dmem_Be    <= be_c;
                        dmem.Dmem_Wdata <= wd_c;
                        off_q           <= Alu_Out_MEM[1:0];
                        f3_q            <= Funct3_MEM;
                        ld_q            <= Load_MEM;
                    end
                end
                // A grant or response in the final budget cycle still completes normally.
                REQ: begin
                    if (dmem.Dmem_Gnt) begin
                        dmem.Dmem_Req <= 1'b0;
                        state         <= ld_q ? WAIT_RSP : DONE;
                        cnt           <= cnt + 1'b1;
                    end else if (cnt >= CNT_LAST) begin
                        dmem.Dmem_Req   <= 1'b0;
                        state           <= DONE;
                        Loaded_Data_MEM <= '0;
                        Timeout_MEM     <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_RSP: begin
                    if (dmem.Dmem_Rvalid) begin
                        Loaded_Data_MEM <= fmt(dmem.Dmem_Rdata, off_q, f3_q);
                        state           <= DONE;
                    end else if (cnt >= CNT_LAST) begin
                        state           <= DONE;
                        Loaded_Data_MEM <= '0;
                        Timeout_MEM     <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    cnt         <= '0;
                    Timeout_MEM <= 1'b0;
                end
            endcase
        end
    end
endmodule
